// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// UART transmitter with a compile-time frame format (5..9 data bits,
// none/odd/even parity, 1 or 2 stop bits) fed by a small input FIFO.
// Frames are sent back to back with no idle gap while the FIFO holds data.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   tx_valid   in   write request
//   tx_ready   out  FIFO can accept a word (level != FIFO_DEPTH)
//   tx_data    in   word to transmit, LSB first
//   tx         out  serial line, idle high, registered
//   tx_busy    out  high whenever the frame FSM is not idle
//   fifo_level out  current FIFO occupancy
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [DATA_BITS-1:0]            tx_data,
  output logic                            tx,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BCW      = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = $clog2(FIFO_DEPTH + 1);
  // Wide enough to count up to 9 data bits or 2 stop bits.
  localparam int NW       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input FIFO. Level is kept separately from the pointers so that full
  // and empty are unambiguous when the pointers are equal.
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (level != LW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t               state;
  state_t               state_d;
  logic [BCW-1:0]       baud_cnt;
  logic [BCW-1:0]       baud_cnt_d;
  logic [NW-1:0]        bit_cnt;
  logic [NW-1:0]        bit_cnt_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 par_bit;
  logic                 par_bit_d;
  logic                 tx_d;
  logic                 baud_done;
  logic                 fifo_has_data;

  assign baud_done     = (baud_cnt == BCW'(BAUD_DIV - 1));
  assign fifo_has_data = (level != '0);
  assign tx_busy       = (state != ST_IDLE);

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    par_bit_d  = par_bit;
    pop        = 1'b0;

    // Baud counter only runs inside a frame and restarts at every bit
    // boundary.
    if (state != ST_IDLE) begin
      baud_cnt_d = baud_done ? '0 : baud_cnt + BCW'(1);
    end

    unique case (state)
      ST_IDLE: begin
        if (fifo_has_data) begin
          pop = 1'b1;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_cnt == NW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt + NW'(1);
            shreg_d   = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          if (bit_cnt == NW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (fifo_has_data) begin
              pop = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt + NW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pop from IDLE or from the end of STOP both load the next frame, so
    // the load is shared here rather than duplicated in each state.
    if (pop) begin
      shreg_d    = head;
      par_bit_d  = calc_par(head);
      bit_cnt_d  = '0;
      baud_cnt_d = '0;
      state_d    = ST_START;
    end

    // Line level is derived from the next state so tx can be registered
    // and still change on the same edge as the state.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      par_bit  <= par_bit_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
// Five instances of uart_tx_cfg in different frame formats share one clock
// and reset. A per-instance monitor samples each bit in its centre and
// compares it with the expected line bits queued when the word was driven.
module tb_uart_tx_cfg;

  localparam int BD = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] vld;
  logic [4:0] rdy;
  logic [4:0] txl;
  logic [4:0] bsy;
  logic [7:0] d0, d1, d2, d4;
  logic [6:0] d3;
  logic [4:0] l0, l1, l2, l3;
  logic [2:0] l4;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  logic exp_bits[$];
  int   start_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .tx_data(d0), .tx(txl[0]), .tx_busy(bsy[0]), .fifo_level(l0));
  // 8E1
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .tx_data(d1), .tx(txl[1]), .tx_busy(bsy[1]), .fifo_level(l1));
  // 8O1
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .tx_data(d2), .tx(txl[2]), .tx_busy(bsy[2]), .fifo_level(l2));
  // 7E2
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .tx_data(d3), .tx(txl[3]), .tx_busy(bsy[3]), .fifo_level(l3));
  // 8N1, 4-entry FIFO
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[4]), .tx_ready(rdy[4]),
    .tx_data(d4), .tx(txl[4]), .tx_busy(bsy[4]), .fifo_level(l4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int fb(input int g);
    case (g)
      1, 2, 3: return 11;
      default: return 10;
    endcase
  endfunction

  function automatic int get_lvl(input int g);
    case (g)
      0: return int'(l0);
      1: return int'(l1);
      2: return int'(l2);
      3: return int'(l3);
      4: return int'(l4);
      default: return -1;
    endcase
  endfunction

  task automatic drive(input int g, input logic [7:0] d);
    case (g)
      0: d0 = d;
      1: d1 = d;
      2: d2 = d;
      3: d3 = d[6:0];
      default: d4 = d;
    endcase
    vld[g] = 1'b1;
  endtask

  // Expected line bits for one frame of instance g.
  task automatic push_exp(input int g, input logic [7:0] d);
    int   nd = (g == 3) ? 7 : 8;
    int   ns = (g == 3) ? 2 : 1;
    logic p  = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      exp_bits.push_back(d[i]);
      p ^= d[i];
    end
    if (g == 1 || g == 3) exp_bits.push_back(p);
    else if (g == 2) exp_bits.push_back(~p);
    for (int i = 0; i < ns; i++) exp_bits.push_back(1'b1);
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_mon
    bit act = 1'b0;
    int cnt = 0;
    always @(negedge clk) begin
      if (!rst_n) begin
        act = 1'b0;
      end else begin
        if (!act && txl[g] === 1'b0) begin
          act = 1'b1;
          cnt = 0;
          start_q.push_back(cyc);
        end
        if (act) begin
          if (cnt % BD == BD / 2) begin
            if (exp_bits.size() == 0) check("sb_underflow", exp_bits.size(), 1);
            else check("frame_bit", txl[g], exp_bits.pop_front());
          end
          cnt++;
          if (cnt == fb(g) * BD) act = 1'b0;
        end
      end
    end
  end

  // One word into an idle, empty instance; checks latency and busy length.
  task automatic send1(input int g, input logic [7:0] d);
    int n;
    @(negedge clk);
    check("ready_idle", rdy[g], 1);
    drive(g, d);
    push_exp(g, d);
    @(posedge clk); #1;
    vld[g] = 1'b0;
    check("acc_level", get_lvl(g), 1);
    check("acc_tx_idle", txl[g], 1);
    @(posedge clk); #1;
    check("start_tx", txl[g], 0);
    check("start_busy", bsy[g], 1);
    check("pop_level", get_lvl(g), 0);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (!bsy[g]) break;
      n++;
    end
    check("busy_len", n, fb(g) * BD);
    check("tx_after", txl[g], 1);
    check("sb_drained", exp_bits.size(), 0);
  endtask

  initial begin
    int         acc;
    int         peak;
    int         t_rdy;
    int         t_end;
    int         spurious;
    logic [7:0] dv;

    vld = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check("rst_tx", txl[g], 1);
      check("rst_busy", bsy[g], 0);
      check("rst_ready", rdy[g], 1);
      check("rst_level", get_lvl(g), 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send1(0, 8'hA5);
    send1(0, 8'hFF);
    send1(0, 8'h00);
    send1(1, 8'hA5);
    send1(2, 8'hA5);
    send1(2, 8'h00);
    send1(3, 8'h41);

    // FIFO fill with tx_valid held high from idle.
    start_q.delete();
    acc  = 0;
    peak = 0;
    dv   = 8'h01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(l4) > peak) peak = int'(l4);
      if (!rdy[4]) break;
      drive(4, dv);
      push_exp(4, dv);
      acc++;
      dv++;
    end
    check("acc_count", acc, 5);
    check("level_peak", peak, 4);
    drive(4, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_level", l4, 4);
      check("full_ready", rdy[4], 0);
    end
    vld[4] = 1'b0;
    t_rdy = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy[4]) begin
        t_rdy = cyc;
        break;
      end
    end
    t_end = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bsy[4]) begin
        t_end = cyc;
        break;
      end
    end
    check("frame_count", start_q.size(), 5);
    if (start_q.size() == 5) begin
      for (int k = 1; k < 5; k++) check("frame_period", start_q[k] - start_q[k-1], 10 * BD);
      check("ready_reassert", t_rdy, start_q[1]);
      check("busy_continuous", t_end - start_q[0], 50 * BD);
    end
    check("sb_drained", exp_bits.size(), 0);

    // Reset in the middle of a frame with two words queued.
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dv = 8'(8'h50 + i);
      drive(4, dv);
      push_exp(4, dv);
    end
    @(negedge clk);
    vld[4] = 1'b0;
    check("queued_level", l4, 2);
    repeat (30) @(negedge clk);
    check("mid_busy", bsy[4], 1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_tx", txl[4], 1);
    check("abort_busy", bsy[4], 0);
    check("abort_level", l4, 0);
    check("abort_ready", rdy[4], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_bits.delete();
    start_q.delete();
    spurious = 0;
    repeat (300) begin
      @(negedge clk);
      if (bsy[4] || !txl[4]) spurious++;
    end
    check("post_rst_quiet", spurious, 0);
    check("post_rst_frames", start_q.size(), 0);
    send1(4, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and an input FIFO with a valid/ready write port. It sits between any byte producer (command/response logic, debug streamers) and the board TX pin. It allows back-to-back frames with no idle gap, so producers never wait for the line to go idle.

## Interface
Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz
- BAUD_RATE, 115200, line rate; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division), must be ≥ 2
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, input FIFO entries, power of 2, ≥ 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_valid  in  1  write request
- tx_ready  out  1  FIFO can accept; equals (fifo_level != FIFO_DEPTH)
- tx_data  in  DATA_BITS  word to send, LSB transmitted first
- tx  out  1  serial line, idle high
- tx_busy  out  1  high whenever FSM is not IDLE
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

## Operation
- Write: a word is accepted on a rising edge with tx_valid && tx_ready. When full, tx_valid is ignored and no data is lost or overwritten.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_level>0, pop the head into the shift register, clear bit/baud counters, enter START.
  - START: tx=0 for BAUD_DIV cycles, then enter DATA.
  - DATA: shift out DATA_BITS bits LSB first, each bit held BAUD_DIV cycles. Next state is PARITY if PARITY≠0, otherwise STOP.
  - PARITY: hold the parity bit for BAUD_DIV cycles, then enter STOP.
    - Even: parity bit = XOR of the data bits.
    - Odd: parity bit = inverted XOR of the data bits.
  - STOP: tx=1 for STOP_BITS×BAUD_DIV cycles. On the final edge:
    - if fifo_level>0, pop and go directly to START (zero idle gap);
    - otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles exactly.
- tx is a registered output with no glitches.
- Simultaneous push and pop: level is unchanged and both take effect.
- Push while full is impossible because tx_ready=0.
- Pointers wrap modulo FIFO_DEPTH. Level is tracked separately so the full and empty states are unambiguous.
- Baud counter width is $clog2(BAUD_DIV). It resets to 0 at each bit boundary and never free-runs in IDLE.

## Timing
- Reset values (asynchronous, taking effect immediately): tx=1, tx_busy=0, tx_ready=1, fifo_level=0, FSM=IDLE, FIFO emptied.
- Reset mid-frame aborts the frame immediately: tx returns high and queued data is discarded.
- Latency, empty FIFO with FSM idle:
  - word accepted at edge k → fifo_level=1 after edge k;
  - pop at edge k+1, so tx=0 and tx_busy=1 from edge k+1;
  - fifo_level returns to 0 after edge k+1.
- tx_busy falls on the same edge that tx completes the last stop bit with an empty FIFO.
- tx_busy stays high continuously across back-to-back frames.
- tx_ready updates one edge after the push or pop that changes the level.

## Test plan
- 8N1, CLK_FREQ=1000000, BAUD_RATE=100000 (BAUD_DIV=10). Push 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. Start bit falls one edge after acceptance. tx_busy is high for exactly 100 cycles.
- PARITY=2 with 0xA5 → parity bit 0, frame 110 cycles. PARITY=1 with 0xA5 → parity bit 1.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x41 → tx = 0,1,0,0,0,0,0,1,0,1,1, 110 cycles total.
- FIFO_DEPTH=4, tx_valid held high from idle with data 0x01,0x02,…:
  - exactly 5 words are accepted before tx_ready=0;
  - fifo_level peaks at 4;
  - 5 frames go out in order with zero gap (period exactly 10×BAUD_DIV);
  - tx_ready reasserts when the second frame starts.
- Push while full: the extra word is dropped, the level stays 4, and the output sequence is unchanged.
- Assert rst_n low during the DATA state of a frame, with 2 words queued:
  - tx goes high immediately, tx_busy=0, fifo_level=0;
  - after release, no frame is sent until a new push.
